// File: rtl/rfphoenix_mcalu16_sched.sv
// rfphoenix_mcalu16_sched: multi-cycle ALU issue scheduler with writeback slot reservation.
// Optional FSIGMOID class enabled by defining RFPHOENIX_MCALU16_SIGMOID_EN.
package rfphoenix_mcalu16_pkg;
  typedef logic [3:0] tid_t;
endpackage

module rfphoenix_mcalu16_sched
  import rfphoenix_mcalu16_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LATW = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*3-1:0]           cls,
  input  logic [NREQ*$bits(tid_t)-1:0] tid,
  input  logic                        hold,
  output logic [NREQ-1:0]             gnt,
  output logic [NREQ-1:0]             err,
  output logic                        issue_v,
  output logic [$clog2(NREQ)-1:0]     issue_sel,
  output tid_t                        issue_tid,
  output logic                        wb_v,
  output logic [$clog2(NREQ)-1:0]     wb_sel,
  output tid_t                        wb_tid,
  output logic                        busy
);

  localparam int SW    = $clog2(NREQ);
  localparam int TW    = $bits(tid_t);
  localparam int NSLOT = 2**LATW - 1;

  logic [NSLOT:1]  resv_q, resv_d;
  logic [SW-1:0]   rsel_q [1:NSLOT];
  logic [SW-1:0]   rsel_d [1:NSLOT];
  tid_t            rtid_q [1:NSLOT];
  tid_t            rtid_d [1:NSLOT];
  logic [SW-1:0]   ptr_q, ptr_d;
  logic            issue_v_q, issue_v_d;
  logic [SW-1:0]   issue_sel_q, issue_sel_d;
  tid_t            issue_tid_q, issue_tid_d;
  logic            wb_v_q, wb_v_d;
  logic [SW-1:0]   wb_sel_q, wb_sel_d;
  tid_t            wb_tid_q, wb_tid_d;

  logic [NREQ-1:0] legal;
  logic [NREQ-1:0] elig;
  logic [LATW-1:0] lat_a [NREQ];
  logic [2:0]      cls_i;
  logic            occ;
  logic            found;
  logic            fire;
  int              win_i;
  logic            win_legal;
  logic [LATW-1:0] win_lat;
  tid_t            win_tid;

  // Class decode, eligibility, round-robin pick and reservation shift.
  always_comb begin
    legal       = '0;
    elig        = '0;
    cls_i       = '0;
    occ         = 1'b0;
    found       = 1'b0;
    fire        = 1'b0;
    win_i       = 0;
    win_legal   = 1'b0;
    win_lat     = '0;
    win_tid     = '0;
    gnt         = '0;
    err         = '0;
    ptr_d       = ptr_q;
    issue_v_d   = 1'b0;
    issue_sel_d = issue_sel_q;
    issue_tid_d = issue_tid_q;
    wb_v_d      = resv_q[1];
    wb_sel_d    = rsel_q[1];
    wb_tid_d    = rtid_q[1];
    for (int i = 0; i < NREQ; i++) begin
      lat_a[i] = '0;
    end

    for (int i = 0; i < NREQ; i++) begin
      cls_i    = cls[i*3 +: 3];
      legal[i] = 1'b1;
      case (cls_i)
        3'd0, 3'd1: lat_a[i] = LATW'(8);
        3'd2:       lat_a[i] = LATW'(7);
        3'd3:       lat_a[i] = LATW'(5);
`ifdef RFPHOENIX_MCALU16_SIGMOID_EN
        3'd4:       lat_a[i] = LATW'(5);
`endif
        default: begin
          legal[i] = 1'b0;
          lat_a[i] = '0;
        end
      endcase
      // A slot at index L+1 now lands on the same wb cycle as a new op.
      occ = 1'b0;
      for (int s = 1; s <= NSLOT; s++) begin
        if (s == int'(lat_a[i]) + 1) occ = resv_q[s];
      end
      elig[i] = req[i] && (!legal[i] || !occ);
    end

    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && elig[i] && i == (int'(ptr_q) + k) % NREQ) begin
          found     = 1'b1;
          win_i     = i;
          win_legal = legal[i];
          win_lat   = lat_a[i];
          win_tid   = tid[i*TW +: TW];
        end
      end
    end

    fire = found && rst && !hold;

    for (int s = 1; s < NSLOT; s++) begin
      resv_d[s] = resv_q[s+1];
      rsel_d[s] = rsel_q[s+1];
      rtid_d[s] = rtid_q[s+1];
    end
    resv_d[NSLOT] = 1'b0;
    rsel_d[NSLOT] = '0;
    rtid_d[NSLOT] = '0;

    if (fire) begin
      ptr_d = SW'((win_i + 1) % NREQ);
      if (win_legal) begin
        gnt         = NREQ'(1) << win_i;
        issue_v_d   = 1'b1;
        issue_sel_d = SW'(win_i);
        issue_tid_d = win_tid;
        for (int s = 1; s <= NSLOT; s++) begin
          if (s == int'(win_lat)) begin
            resv_d[s] = 1'b1;
            rsel_d[s] = SW'(win_i);
            rtid_d[s] = win_tid;
          end
        end
      end else begin
        err = NREQ'(1) << win_i;
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      resv_q      <= '0;
      ptr_q       <= '0;
      issue_v_q   <= 1'b0;
      issue_sel_q <= '0;
      issue_tid_q <= '0;
      wb_v_q      <= 1'b0;
      wb_sel_q    <= '0;
      wb_tid_q    <= '0;
      for (int s = 1; s <= NSLOT; s++) begin
        rsel_q[s] <= '0;
        rtid_q[s] <= '0;
      end
    end else begin
      resv_q      <= resv_d;
      ptr_q       <= ptr_d;
      issue_v_q   <= issue_v_d;
      issue_sel_q <= issue_sel_d;
      issue_tid_q <= issue_tid_d;
      wb_v_q      <= wb_v_d;
      wb_sel_q    <= wb_sel_d;
      wb_tid_q    <= wb_tid_d;
      for (int s = 1; s <= NSLOT; s++) begin
        rsel_q[s] <= rsel_d[s];
        rtid_q[s] <= rtid_d[s];
      end
    end
  end

  assign issue_v   = issue_v_q;
  assign issue_sel = issue_sel_q;
  assign issue_tid = issue_tid_q;
  assign wb_v      = wb_v_q;
  assign wb_sel    = wb_sel_q;
  assign wb_tid    = wb_tid_q;
  assign busy      = (|resv_q) | issue_v_q;

endmodule
